dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-master arbiter that shares the single word-addressed data-memory port (addr / byteen / wdata / rdata, combinational read, write on clock edge) between the CPU load/store port (M0) and a DMA/debug master (M1). It sits between the `mips` core's `m_data_*` interface and the data memory. It provides:
- grant selection each cycle;
- a bounded lock for bursts;
- registered read return;
- out-of-range write suppression.

## Interface
Parameters:
- `DM_WORDS`, 4096, number of 32-bit words in data memory; word index ≥ `DM_WORDS` is out of range
- `MAX_BURST`, 4, maximum consecutive locked grants to one master while the other is requesting

Ports (x ∈ {0,1}):
- `clk`  in  1  single clock. All state is on its rising edge.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low
- `mx_req`  in  1  master x requests an access this cycle
- `mx_lock`  in  1  master x asks to keep ownership after this access
- `mx_addr`  in  32  byte address; bits [1:0] ignored
- `mx_byteen`  in  4  byte write enables; 4'b0000 = read
- `mx_wdata`  in  32  write data
- `mx_gnt`  out  1  combinational; access performed this cycle
- `mx_rvalid`  out  1  registered; read data valid for the access granted last cycle
- `mx_rdata`  out  32  registered read data
- `mx_err`  out  1  registered; the access granted last cycle was out of range
- `dm_addr`  out  32  winner address with bits [1:0] forced to 0
- `dm_byteen`  out  4  winner byteen; 0 when there is no grant, when the access is out of range, or while `reset_n` = 0
- `dm_wdata`  out  32  winner write data
- `dm_rdata`  in  32  combinational memory read data

## Operation
Registered state:
- `own` ∈ {NONE, M0, M1}
- `last` (winner of the most recent non-locked arbitration)
- `bcnt` (burst counter, 0..MAX_BURST)

Winner selection, each cycle:
- If `own`=Mx, `mx_req`=1, `mx_lock`=1, and (`bcnt` < MAX_BURST or the other master is idle), then the winner is Mx.
- Otherwise, if exactly one master requests, it wins.
- If both request, the winner is the master ≠ `last` (round-robin).
- If neither requests, the winner is none: `gnt`=0, `dm_byteen`=0, `dm_addr`/`dm_wdata` = M0 values.

Update at the edge:
- `own` ← winner if winner `lock`=1, else NONE.
- `bcnt` ← `bcnt`+1 on a locked continuation, 1 on a fresh locked grant, 0 otherwise. It saturates at MAX_BURST.
- `last` ← winner whenever a grant occurs.

Burst limit:
- When the limit is hit while the other master requests, the other master wins that cycle.
- `bcnt` restarts from the new owner.

Accesses:
- A write commits at the edge ending the grant cycle.
- A read captures `dm_rdata` into `mx_rdata` at that edge.
- `mx_rvalid` is pulsed for 1 cycle for reads only.
- Out-of-range access (`mx_addr[31:2]` ≥ DM_WORDS):
  - the grant is still given and `dm_byteen` is forced to 0;
  - the next cycle has `mx_err`=1 and `mx_rvalid`=1, and for reads `mx_rdata`=0.
- `mx_rdata` holds its value between pulses.

## Timing
- Grant: 0-cycle latency, combinational from `req`/`lock` and registered state.
- Read data: 1-cycle latency. Back-to-back grants give back-to-back `rvalid`.
- Reset values:
  - outputs: `mx_gnt`=0, `mx_rvalid`=0, `mx_rdata`=0, `mx_err`=0, `dm_byteen`=0;
  - state: `own`=NONE, `last`=M1 (so M0 wins the first tie), `bcnt`=0.
- Reset asserted mid-access:
  - the write is not committed, because `dm_byteen` is forced to 0 asynchronously;
  - the pending `rvalid`/`err` is dropped.
- A locked owner that drops `req` releases ownership at the same edge. `lock` without `req` has no effect.
- `mx_req` may change every cycle; no hold-until-grant rule is imposed on masters, but the `mips` core holds its request while stalled.

## Configuration
- `DM_ARB_RR_EN` defined: round-robin tie-break as above.
- `DM_ARB_RR_EN` undefined: fixed priority, M0 wins every tie and `last` is unused. Lock and burst limit are unchanged.

## Structure
- Package `dm_arb_pkg`:
  - `own_t` enum {OWN_NONE, OWN_M0, OWN_M1};
  - constants `BYTEEN_W`=4 and `DM_WORDS_DEF`=4096.
- One sub-module, `dm_arb_pick`: combinational winner selection from `req`, `lock`, `own`, `bcnt` and `last`. The top holds the registers, the data muxing and the return path.

## Test plan
1. Reset: `reset_n`=0 with both `req`=1 and `m0_byteen`=4'hf → `gnt`=0, `dm_byteen`=0, `rvalid`=0. After release, the first tie goes to M0.
2. Round-robin reads: both `req`, M0 addr 0x10, M1 addr 0x20, memory words 0xAAAA0000 / 0xBBBB0000 → grants alternate M0, M1, M0…. Each `rvalid` comes 1 cycle after its grant with the matching data.
3. Locked burst: M1 `lock`=1 and `req` continuous, M0 `req` continuous → M1 granted 4 consecutive cycles, M0 granted the 5th, then M1 for 4 more.
4. Out of range: M0 write to 0x4000 with `byteen` 4'hf, data 0x12345678 → `m0_gnt`=1, `dm_byteen`=0, next cycle `m0_err`=1, memory unchanged.
5. Reset mid-read: M0 read granted, `reset_n` pulled low before the edge → `m0_rvalid` stays 0 and `m0_rdata`=0.
6. `DM_ARB_RR_EN` undefined, both `req` continuous with no lock → M0 granted every cycle, `m1_gnt` stays 0.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_M0,
    OWN_M1
  } own_t;

  localparam int BYTEEN_W     = 4;
  localparam int DM_WORDS_DEF = 4096;

  function automatic own_t own_of(input logic idx);
    return idx ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// One master's load/store channel into the data-memory arbiter.
interface dm_arbiter_if;
  import dm_arb_pkg::*;

  logic                req;
  logic                lock;
  logic [31:0]         addr;
  logic [BYTEEN_W-1:0] byteen;
  logic [31:0]         wdata;
  logic                gnt;
  logic                rvalid;
  logic [31:0]         rdata;
  logic                err;

  modport master (
    output req, lock, addr, byteen, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, lock, addr, byteen, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/dm_arb_pick.sv
// Combinational winner selection: locked owner, burst-limit handover, then tie-break.
// DM_ARB_RR_EN selects round-robin ties; otherwise M0 wins every tie.
module dm_arb_pick
  import dm_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int BCNT_W    = 3
) (
  input  logic [1:0]        req,
  input  logic [1:0]        lock,
  input  own_t              own,
  input  logic [BCNT_W-1:0] bcnt,
  input  logic              last,
  output logic              win_valid,
  output logic              win_idx,
  output logic              win_cont
);

  logic [1:0] hold;
  logic [1:0] expired;
  logic       tie_idx;

  // hold: owner keeps the port; expired: owner wants it but has used its burst
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_own
      logic owned;
      assign owned       = (own == own_of(1'(gi)));
      assign hold[gi]    = owned & req[gi] & lock[gi] &
                           ((bcnt < BCNT_W'(MAX_BURST)) | ~req[1-gi]);
      assign expired[gi] = owned & req[gi] & lock[gi] & ~hold[gi];
    end
  endgenerate

`ifdef DM_ARB_RR_EN
  assign tie_idx = ~last;
`else
  logic unused_last;
  assign unused_last = last;
  assign tie_idx     = 1'b0;
`endif

  always_comb begin
    win_valid = |req;
    win_idx   = 1'b0;
    win_cont  = 1'b0;
    if (hold[0]) begin
      win_cont = 1'b1;
    end else if (hold[1]) begin
      win_idx  = 1'b1;
      win_cont = 1'b1;
    end else if (expired[0]) begin
      win_idx = 1'b1;
    end else if (expired[1]) begin
      win_idx = 1'b0;
    end else if (req == 2'b10) begin
      win_idx = 1'b1;
    end else if (req == 2'b11) begin
      win_idx = tie_idx;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter for the single-port data memory with locked bursts and registered read return.
// Tie-break policy is set by DM_ARB_RR_EN (round-robin when defined, fixed M0 priority otherwise).
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DM_WORDS  = DM_WORDS_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  dm_arbiter_if.slave         m0,
  dm_arbiter_if.slave         m1,
  output logic [31:0]         dm_addr,
  output logic [BYTEEN_W-1:0] dm_byteen,
  output logic [31:0]         dm_wdata,
  input  logic [31:0]         dm_rdata
);

  localparam int BCNT_W = $clog2(MAX_BURST + 1);

  own_t              own_reg;
  logic              last_reg;
  logic [BCNT_W-1:0] bcnt_reg;

  logic [1:0]          req;
  logic [1:0]          lock;
  logic                win_valid;
  logic                win_idx;
  logic                win_cont;
  logic                gnt_any;
  logic [31:0]         win_addr;
  logic [31:0]         win_wdata;
  logic [BYTEEN_W-1:0] win_byteen;
  logic                win_lock;
  logic                win_oor;
  logic                win_read;

  assign req  = {m1.req, m0.req};
  assign lock = {m1.lock, m0.lock};

  dm_arb_pick #(
    .MAX_BURST (MAX_BURST),
    .BCNT_W    (BCNT_W)
  ) u_pick (
    .req       (req),
    .lock      (lock),
    .own       (own_reg),
    .bcnt      (bcnt_reg),
    .last      (last_reg),
    .win_valid (win_valid),
    .win_idx   (win_idx),
    .win_cont  (win_cont)
  );

  // With no request win_idx is 0, so the memory sees M0's address and data.
  assign win_addr   = win_idx ? m1.addr   : m0.addr;
  assign win_wdata  = win_idx ? m1.wdata  : m0.wdata;
  assign win_byteen = win_idx ? m1.byteen : m0.byteen;
  assign win_lock   = win_idx ? m1.lock   : m0.lock;
  assign win_oor    = (win_addr[31:2] >= 30'(DM_WORDS));
  assign win_read   = (win_byteen == '0);

  // Reset gates the strobes directly so an in-flight write can never commit.
  assign gnt_any   = win_valid & reset_n;
  assign m0.gnt    = gnt_any & ~win_idx;
  assign m1.gnt    = gnt_any & win_idx;
  assign dm_addr   = {win_addr[31:2], 2'b00};
  assign dm_wdata  = win_wdata;
  assign dm_byteen = (gnt_any & ~win_oor) ? win_byteen : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own_reg  <= OWN_NONE;
      last_reg <= 1'b1;
      bcnt_reg <= '0;
    end else if (win_valid) begin
      last_reg <= win_idx;
      if (win_lock) begin
        own_reg <= own_of(win_idx);
        if (!win_cont) begin
          bcnt_reg <= BCNT_W'(1);
        end else if (bcnt_reg != BCNT_W'(MAX_BURST)) begin
          bcnt_reg <= bcnt_reg + 1'b1;
        end
      end else begin
        own_reg  <= OWN_NONE;
        bcnt_reg <= '0;
      end
    end else begin
      own_reg  <= OWN_NONE;
      bcnt_reg <= '0;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      logic        granted;
      logic        rvalid_reg;
      logic        err_reg;
      logic [31:0] rdata_reg;

      assign granted = win_valid & (win_idx == 1'(gi));

      // Out-of-range accesses still return a pulse so the master never waits forever.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rvalid_reg <= 1'b0;
          err_reg    <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= granted & (win_read | win_oor);
          err_reg    <= granted & win_oor;
          if (granted & win_read) begin
            rdata_reg <= win_oor ? '0 : dm_rdata;
          end
        end
      end
    end
  endgenerate

  assign m0.rvalid = g_ret[0].rvalid_reg;
  assign m0.err    = g_ret[0].err_reg;
  assign m0.rdata  = g_ret[0].rdata_reg;
  assign m1.rvalid = g_ret[1].rvalid_reg;
  assign m1.err    = g_ret[1].err_reg;
  assign m1.rdata  = g_ret[1].rdata_reg;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_dm_arbiter;

  localparam int MAX_BURST = 4;
  localparam int NWORDS    = 4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] dm_addr;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  dm_arbiter_if m0_if ();
  dm_arbiter_if m1_if ();

  dm_arbiter #(
    .DM_WORDS  (NWORDS),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .dm_addr   (dm_addr),
    .dm_byteen (dm_byteen),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit verbose = 1'b1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Memory attached to the DUT
  logic [31:0] tb_mem [0:NWORDS-1];
  assign dm_rdata = tb_mem[dm_addr[13:2]];

  initial begin
    for (int i = 0; i < NWORDS; i++) tb_mem[i] = 32'h0;
    tb_mem[4] = 32'hAAAA0000;
    tb_mem[8] = 32'hBBBB0000;
    forever begin
      @(posedge clk);
      if (dm_byteen != 4'h0)
        tb_mem[dm_addr[13:2]] <= (tb_mem[dm_addr[13:2]] & ~byte_mask(dm_byteen)) |
                                 (dm_wdata & byte_mask(dm_byteen));
    end
  end

  // ---------------- behavioural model ----------------
  logic [31:0] shadow [0:NWORDS-1];
  int          m_own, m_last, m_bcnt;
  bit          m_rv [2];
  bit          m_er [2];
  logic [31:0] m_rd [2];
  int          n_own, n_last, n_bcnt;
  bit          n_rv [2];
  bit          n_er [2];
  logic [31:0] n_rd [2];
  bit          n_wr;
  logic [11:0] n_widx;
  logic [31:0] n_wdata;
  logic [3:0]  n_wbe;

  function automatic int model_pick(input bit r0, input bit r1, input bit l0, input bit l1,
                                    input int own, input int bcnt, input int last);
    bit r [2];
    bit l [2];
    r[0] = r0; r[1] = r1; l[0] = l0; l[1] = l1;
    if (own >= 0 && r[own] && l[own]) begin
      if (bcnt < MAX_BURST || !r[1-own]) return own;
      return 1 - own;
    end
    if (r[0] && r[1]) begin
`ifdef DM_ARB_RR_EN
      return 1 - last;
`else
      return 0;
`endif
    end
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin
    int          w;
    logic [31:0] a_w, wd_w;
    logic [3:0]  be_w;
    logic [29:0] word;
    bit          oor, lk_w, rd_w;

    w = reset_n ? model_pick(m0_if.req, m1_if.req, m0_if.lock, m1_if.lock, m_own, m_bcnt, m_last) : -1;
    a_w  = (w == 1) ? m1_if.addr   : m0_if.addr;
    wd_w = (w == 1) ? m1_if.wdata  : m0_if.wdata;
    be_w = (w == 1) ? m1_if.byteen : m0_if.byteen;
    lk_w = (w == 1) ? m1_if.lock   : m0_if.lock;
    word = a_w[31:2];
    oor  = (word >= 30'(NWORDS));
    rd_w = (be_w == 4'h0);

    chk("m0_gnt", 32'(m0_if.gnt), 32'(w == 0));
    chk("m1_gnt", 32'(m1_if.gnt), 32'(w == 1));
    chk("dm_byteen", 32'(dm_byteen), (w >= 0 && !oor) ? 32'(be_w) : 32'h0);
    if (reset_n) begin
      chk("dm_addr", dm_addr, {a_w[31:2], 2'b00});
      chk("dm_wdata", dm_wdata, wd_w);
    end
    chk("m0_rvalid", 32'(m0_if.rvalid), 32'(m_rv[0]));
    chk("m0_err", 32'(m0_if.err), 32'(m_er[0]));
    chk("m0_rdata", m0_if.rdata, m_rd[0]);
    chk("m1_rvalid", 32'(m1_if.rvalid), 32'(m_rv[1]));
    chk("m1_err", 32'(m1_if.err), 32'(m_er[1]));
    chk("m1_rdata", m1_if.rdata, m_rd[1]);

    if (verbose && w >= 0)
      $display("[TB] t=%0t grant M%0d addr=%h byteen=%h lock=%0d%s", $time, w, a_w, be_w, lk_w,
               oor ? " out-of-range" : "");

    n_last = m_last;
    n_own  = -1;
    n_bcnt = 0;
    n_wr   = 1'b0;
    for (int x = 0; x < 2; x++) begin
      n_rv[x] = (w == x) && (rd_w || oor);
      n_er[x] = (w == x) && oor;
      n_rd[x] = ((w == x) && rd_w) ? (oor ? 32'h0 : shadow[word[11:0]]) : m_rd[x];
    end
    if (w >= 0) begin
      n_last = w;
      if (lk_w) begin
        n_own  = w;
        n_bcnt = (m_own == w) ? ((m_bcnt + 1 > MAX_BURST) ? MAX_BURST : m_bcnt + 1) : 1;
      end
      n_wr    = !oor && !rd_w;
      n_widx  = word[11:0];
      n_wdata = wd_w;
      n_wbe   = be_w;
    end
  end

  initial begin
    for (int i = 0; i < NWORDS; i++) shadow[i] = 32'h0;
    shadow[4] = 32'hAAAA0000;
    shadow[8] = 32'hBBBB0000;
    m_own = -1; m_last = 1; m_bcnt = 0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_own = -1; m_last = 1; m_bcnt = 0;
        for (int x = 0; x < 2; x++) begin
          m_rv[x] = 1'b0; m_er[x] = 1'b0; m_rd[x] = 32'h0;
        end
      end else begin
        m_own = n_own; m_last = n_last; m_bcnt = n_bcnt;
        for (int x = 0; x < 2; x++) begin
          m_rv[x] = n_rv[x]; m_er[x] = n_er[x]; m_rd[x] = n_rd[x];
        end
        if (n_wr)
          shadow[n_widx] = (shadow[n_widx] & ~byte_mask(n_wbe)) | (n_wdata & byte_mask(n_wbe));
      end
    end
  end

  // ---------------- stimulus ----------------
  int t2_exp [4];
  int t3_exp [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cur_winner();
    if (m0_if.gnt) return 0;
    if (m1_if.gnt) return 1;
    return -1;
  endfunction

  task automatic idle();
    m0_if.req = 1'b0; m0_if.lock = 1'b0;
    m1_if.req = 1'b0; m1_if.lock = 1'b0;
  endtask

  initial begin
    logic [29:0] word;
    logic [31:0] addr;
    int          sel;

`ifdef DM_ARB_RR_EN
    t2_exp = '{0, 1, 0, 1};
    t3_exp = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
`else
    t2_exp = '{0, 0, 0, 0};
    t3_exp = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
`endif

    // Reset with both masters requesting and M0 presenting a write
    m0_if.req = 1'b1; m0_if.lock = 1'b0; m0_if.addr = 32'h10; m0_if.byteen = 4'hf; m0_if.wdata = 32'hDEADBEEF;
    m1_if.req = 1'b1; m1_if.lock = 1'b0; m1_if.addr = 32'h20; m1_if.byteen = 4'h0; m1_if.wdata = 32'h0;
    @(negedge clk);
    chk("rst_m0_gnt", 32'(m0_if.gnt), 32'h0);
    chk("rst_m1_gnt", 32'(m1_if.gnt), 32'h0);
    chk("rst_dm_byteen", 32'(dm_byteen), 32'h0);
    chk("rst_m0_rvalid", 32'(m0_if.rvalid), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Both read; tie-break policy and 1-cycle read return
    m0_if.byteen = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_winner", 32'(cur_winner()), 32'(t2_exp[k]));
      if (k > 0) begin
        if (t2_exp[k-1] == 0) begin
          chk("t2_m0_rvalid", 32'(m0_if.rvalid), 32'h1);
          chk("t2_m0_rdata", m0_if.rdata, 32'hAAAA0000);
        end else begin
          chk("t2_m1_rvalid", 32'(m1_if.rvalid), 32'h1);
          chk("t2_m1_rdata", m1_if.rdata, 32'hBBBB0000);
        end
      end
      tick();
    end
    idle();
    tick();

    // Locked burst from M1 against continuous M0 requests
    m1_if.req = 1'b1; m1_if.lock = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 1) m0_if.req = 1'b1;
      @(negedge clk);
      chk("t3_winner", 32'(cur_winner()), 32'(t3_exp[k]));
      tick();
    end
    idle();
    tick();

    // Out-of-range write
    m0_if.req = 1'b1; m0_if.addr = 32'h4000; m0_if.byteen = 4'hf; m0_if.wdata = 32'h12345678;
    @(negedge clk);
    chk("t4_m0_gnt", 32'(m0_if.gnt), 32'h1);
    chk("t4_dm_byteen", 32'(dm_byteen), 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("t4_m0_err", 32'(m0_if.err), 32'h1);
    chk("t4_m0_rvalid", 32'(m0_if.rvalid), 32'h1);
    chk("t4_mem0", tb_mem[0], 32'h0);
    tick();

    // Reset asserted while a read is granted
    m0_if.req = 1'b1; m0_if.addr = 32'h10; m0_if.byteen = 4'h0;
    @(negedge clk);
    chk("t5_m0_gnt", 32'(m0_if.gnt), 32'h1);
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_m0_rvalid", 32'(m0_if.rvalid), 32'h0);
    chk("t5_m0_rdata", m0_if.rdata, 32'h0);
    reset_n = 1'b1;
    idle();
    tick();

    // Random traffic against the model
    verbose = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int x = 0; x < 2; x++) begin
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      word = 30'(NWORDS + int'($urandom_range(0, 3)));
        else if (sel == 1) word = 30'(NWORDS - 1);
        else               word = 30'($urandom_range(0, 15));
        addr = {word, 2'($urandom_range(0, 3))};
        if (x == 0) begin
          m0_if.req    = ($urandom_range(0, 3) != 0);
          m0_if.lock   = $urandom_range(0, 1) == 1;
          m0_if.addr   = addr;
          m0_if.byteen = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
          m0_if.wdata  = $urandom;
        end else begin
          m1_if.req    = ($urandom_range(0, 3) != 0);
          m1_if.lock   = $urandom_range(0, 1) == 1;
          m1_if.addr   = addr;
          m1_if.byteen = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
          m1_if.wdata  = $urandom;
        end
      end
      tick();
    end
    idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
